// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: fetch/decode control FSM states and control bundle.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_IWAIT  = 2'b01,
    ST_IKILL  = 2'b10,
    ST_TRAPFL = 2'b11
  } fd_state_e;

  typedef struct packed {
    logic pc_stall;
    logic fd_hold;
    logic fd_flush;
    logic de_flush;
  } fd_ctrl_t;

  localparam fd_ctrl_t FD_CTRL_NONE = '0;

  // Drives PC hold plus F/D squash while fetch data is absent.
  localparam fd_ctrl_t FD_CTRL_WAIT = '{pc_stall: 1'b1, fd_hold: 1'b0,
                                        fd_flush: 1'b1, de_flush: 1'b0};

  // Control-flow change: PC loads the new target, both pipe registers squash.
  localparam fd_ctrl_t FD_CTRL_KILL = '{pc_stall: 1'b0, fd_hold: 1'b0,
                                        fd_flush: 1'b1, de_flush: 1'b1};

endpackage

// File: rtl/riscv_fdctrl_if.sv
// Hazard/fetch status into the F/D controller and pipeline-register controls out.
// Master is the pipeline side, slave is the controller.
interface riscv_fdctrl_if #(
  parameter int CNT_W = 32
);
  logic             i_riscv_fdctrl_loaduse;
  logic             i_riscv_fdctrl_imiss;
  logic             i_riscv_fdctrl_iready;
  logic             i_riscv_fdctrl_redirect;
  logic             i_riscv_fdctrl_trap;
  logic             i_riscv_fdctrl_cntclr;
  logic             o_riscv_fdctrl_pc_stall;
  logic             o_riscv_fdctrl_fd_hold;
  logic             o_riscv_fdctrl_fd_flush;
  logic             o_riscv_fdctrl_de_flush;
  logic [1:0]       o_riscv_fdctrl_state;
  logic [CNT_W-1:0] o_riscv_fdctrl_stallcnt;

  modport master (
    output i_riscv_fdctrl_loaduse, i_riscv_fdctrl_imiss, i_riscv_fdctrl_iready,
           i_riscv_fdctrl_redirect, i_riscv_fdctrl_trap, i_riscv_fdctrl_cntclr,
    input  o_riscv_fdctrl_pc_stall, o_riscv_fdctrl_fd_hold, o_riscv_fdctrl_fd_flush,
           o_riscv_fdctrl_de_flush, o_riscv_fdctrl_state, o_riscv_fdctrl_stallcnt
  );

  modport slave (
    input  i_riscv_fdctrl_loaduse, i_riscv_fdctrl_imiss, i_riscv_fdctrl_iready,
           i_riscv_fdctrl_redirect, i_riscv_fdctrl_trap, i_riscv_fdctrl_cntclr,
    output o_riscv_fdctrl_pc_stall, o_riscv_fdctrl_fd_hold, o_riscv_fdctrl_fd_flush,
           o_riscv_fdctrl_de_flush, o_riscv_fdctrl_state, o_riscv_fdctrl_stallcnt
  );
endinterface

// File: rtl/riscv_fdctrl.sv
// Fetch/decode pipeline controller: PC stall, F/D hold/flush, D/E bubble, stall counter.
// Controls are combinational from state and inputs (zero latency); it never backpressures.
module riscv_fdctrl
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic           i_riscv_fdctrl_clk,
  input  logic           i_riscv_fdctrl_rst,
  riscv_fdctrl_if.slave  fd_if
);

  fd_state_e        state_q, state_d;
  fd_ctrl_t         ctrl;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic loaduse, imiss, iready, redirect, trap;
  assign loaduse  = fd_if.i_riscv_fdctrl_loaduse;
  assign imiss    = fd_if.i_riscv_fdctrl_imiss;
  assign iready   = fd_if.i_riscv_fdctrl_iready;
  assign redirect = fd_if.i_riscv_fdctrl_redirect;
  assign trap     = fd_if.i_riscv_fdctrl_trap;

  always_comb begin
    ctrl    = FD_CTRL_NONE;
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (trap) begin
          ctrl    = FD_CTRL_KILL;
          state_d = ST_TRAPFL;
        end else if (redirect) begin
          ctrl = FD_CTRL_KILL;
        end else if (loaduse) begin
          // A concurrent imiss stays asserted and is picked up next cycle.
          ctrl.pc_stall = 1'b1;
          ctrl.fd_hold  = 1'b1;
          ctrl.de_flush = 1'b1;
        end else if (imiss) begin
          ctrl    = FD_CTRL_WAIT;
          state_d = ST_IWAIT;
        end
      end
      ST_IWAIT: begin
        if (redirect || trap) begin
          ctrl    = FD_CTRL_KILL;
          state_d = iready ? ST_RUN : ST_IKILL;
        end else if (iready) begin
          state_d = ST_RUN;
        end else begin
          ctrl = FD_CTRL_WAIT;
        end
      end
      ST_IKILL: begin
        // The returning fetch is wrong-path: squash it, then release the PC.
        ctrl          = FD_CTRL_WAIT;
        ctrl.de_flush = redirect || trap;
        if (iready) begin
          ctrl.pc_stall = 1'b0;
          state_d       = ST_RUN;
        end
      end
      ST_TRAPFL: begin
        ctrl    = FD_CTRL_KILL;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    if (i_riscv_fdctrl_rst) begin
      ctrl = '{pc_stall: 1'b1, fd_hold: 1'b0, fd_flush: 1'b1, de_flush: 1'b1};
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (fd_if.i_riscv_fdctrl_cntclr) begin
      cnt_d = '0;
    end else if (ctrl.pc_stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_riscv_fdctrl_clk or posedge i_riscv_fdctrl_rst) begin
    if (i_riscv_fdctrl_rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fd_if.o_riscv_fdctrl_pc_stall = ctrl.pc_stall;
  assign fd_if.o_riscv_fdctrl_fd_hold  = ctrl.fd_hold;
  assign fd_if.o_riscv_fdctrl_fd_flush = ctrl.fd_flush;
  assign fd_if.o_riscv_fdctrl_de_flush = ctrl.de_flush;
  assign fd_if.o_riscv_fdctrl_state    = state_q;
  assign fd_if.o_riscv_fdctrl_stallcnt = cnt_q;

endmodule
